shading_seq: RTL

Sequenced, resource-shared version of the GPU pixel shading multiply. One 9×5 unsigned multiplier and one 9→8 positive clamp are time-multiplexed across the R, G and B channels under a small FSM. Input and output use valid/ready handshakes. The block sits between the rasterizer's per-pixel colour interpolation and the blend/write-back stage, and is used where area matters more than one-pixel-per-clock throughput.

---
 rtl/shading_if.sv | 31 +++
 rtl/shading_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/shading_if.sv
// Valid/ready pixel bus between colour interpolation and the sequenced shading multiply.
// The master drives pixels and output-side ready; the slave is the shading block.
interface shading_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] rTex;
    logic [4:0] gTex;
    logic [4:0] bTex;
    logic       noTexture;
    logic [8:0] rGouraud;
    logic [8:0] gGouraud;
    logic [8:0] bGouraud;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] rOut;
    logic [7:0] gOut;
    logic [7:0] bOut;
    logic       busy;

    modport master (
        output in_valid, rTex, gTex, bTex, noTexture,
               rGouraud, gGouraud, bGouraud, out_ready,
        input  in_ready, out_valid, rOut, gOut, bOut, busy
    );

    modport slave (
        input  in_valid, rTex, gTex, bTex, noTexture,
               rGouraud, gGouraud, bGouraud, out_ready,
        output in_ready, out_valid, rOut, gOut, bOut, busy
    );
endinterface

// File: rtl/shading_seq.sv
// Pixel shading multiply (Gouraud x texel) with one shared 9x5 multiplier and clamp,
// stepped through R, G, B by a small FSM behind valid/ready handshakes.
module shading_seq (
    input  logic     clk,
    input  logic     i_nrst,
    shading_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_R = 3'd1,
        MUL_G = 3'd2,
        MUL_B = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     r_state;
    logic [4:0] r_tex_r, r_tex_g, r_tex_b;
    logic [8:0] r_gou_r, r_gou_g, r_gou_b;
    logic [7:0] r_out_r, r_out_g, r_out_b;

    logic       w_accept;
    logic [4:0] w_tex;
    logic [8:0] w_gou;
    logic [8:0] w_scaled;
    logic [7:0] w_shade;

    // Values of 256 and above only arise from Gouraud overbright; saturate to white.
    function automatic logic [7:0] sat_clamp(input logic [8:0] x);
        return x[8] ? 8'hFF : x[7:0];
    endfunction

    assign bus.in_ready  = i_nrst && ((r_state == IDLE) ||
                                      (r_state == DONE && bus.out_ready));
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.rOut      = r_out_r;
    assign bus.gOut      = r_out_g;
    assign bus.bOut      = r_out_b;

    assign w_accept = bus.in_valid && bus.in_ready;

    always_comb begin
        w_tex = 5'd0;
        w_gou = 9'd0;
        case (r_state)
            MUL_R: begin w_tex = r_tex_r; w_gou = r_gou_r; end
            MUL_G: begin w_tex = r_tex_g; w_gou = r_gou_g; end
            MUL_B: begin w_tex = r_tex_b; w_gou = r_gou_b; end
            default: begin w_tex = 5'd0; w_gou = 9'd0; end
        endcase
    end

    // Single shared multiplier; the full 14-bit product is kept before dropping 5 LSBs.
    assign w_scaled = 9'(({5'd0, w_gou} * {9'd0, w_tex}) >> 5);
    assign w_shade  = sat_clamp(w_scaled);

    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            r_state <= IDLE;
            r_tex_r <= '0;
            r_tex_g <= '0;
            r_tex_b <= '0;
            r_gou_r <= '0;
            r_gou_g <= '0;
            r_gou_b <= '0;
            r_out_r <= '0;
            r_out_g <= '0;
            r_out_b <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_tex_r <= bus.rTex | {5{bus.noTexture}};
                        r_tex_g <= bus.gTex | {5{bus.noTexture}};
                        r_tex_b <= bus.bTex | {5{bus.noTexture}};
                        r_gou_r <= bus.rGouraud;
                        r_gou_g <= bus.gGouraud;
                        r_gou_b <= bus.bGouraud;
                        r_state <= MUL_R;
                    end else if (r_state == DONE && bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                MUL_R: begin
                    r_out_r <= w_shade;
                    r_state <= MUL_G;
                end
                MUL_G: begin
                    r_out_g <= w_shade;
                    r_state <= MUL_B;
                end
                MUL_B: begin
                    r_out_b <= w_shade;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
